// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the instruction-fetch stage of the single-issue MIPS
// lab core.
//   fetch_state_e : fetch FSM encoding (BOOT, RUN, HALT)
//   if_id_t       : IF/ID pipeline register contents
//   TEXT_BASE     : SPIM text segment base, ROM word 0
//   INST_NOP      : all-zero instruction word (sll $0,$0,0)
//   WORD_BYTES    : bytes per instruction word
//   align_word()  : clears the byte offset of an address
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    // Instructions are word aligned; the low two address bits carry no meaning
    // and are simply dropped rather than trapped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   stall, redirect_valid, redirect_pc : control from decode / branch unit
//   imem_addr, imem_data               : instruction ROM address / read data
//   if_id_valid/inst/pc/pc_plus4       : IF/ID pipeline register to decode
//   halted, fetch_count                : status
// Modports:
//   master : the fetch stage (drives address, IF/ID and status)
//   slave  : the surrounding core (drives control and ROM data)
// -----------------------------------------------------------------------------
interface if_fetch_stage_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   stall;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic [31:0]            imem_addr;
    logic [31:0]            imem_data;
    logic                   if_id_valid;
    logic [31:0]            if_id_inst;
    logic [31:0]            if_id_pc;
    logic [31:0]            if_id_pc_plus4;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4,
               halted, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4,
               halted, fetch_count
    );
endinterface

// File: rtl/if_fetch_stage_next_pc.sv
// -----------------------------------------------------------------------------
// if_next_pc
// Combinational next-PC select for the fetch stage.
//   state_i          : current fetch FSM state
//   pc_i             : current PC register
//   stall_i          : hold request from decode / hazard unit
//   redirect_valid_i : branch/jump taken this cycle
//   redirect_pc_i    : branch/jump target (low two bits ignored)
//   pc_o             : PC to load on the next edge
//   advance_o        : the instruction at pc_i is captured this edge
//   flush_o          : a redirect discards the IF/ID contents this edge
//   last_o           : the captured instruction is the final ROM word
// Priority in RUN is redirect > stall > advance. In HALT only a redirect
// moves the PC. In BOOT everything is ignored.
// -----------------------------------------------------------------------------
module if_next_pc
    import core_pkg::*;
#(
    parameter logic [31:0] LAST_PC = 32'h0040_007C
) (
    input  fetch_state_e state_i,
    input  logic [31:0]  pc_i,
    input  logic         stall_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    output logic [31:0]  pc_o,
    output logic         advance_o,
    output logic         flush_o,
    output logic         last_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_o      = pc_i;
        advance_o = 1'b0;
        flush_o   = 1'b0;
        last_o    = 1'b0;

        unique case (state_i)
            ST_RUN: begin
                if (redirect_valid_i) begin
                    pc_o    = align_word(redirect_pc_i);
                    flush_o = 1'b1;
                end else if (!stall_i) begin
                    advance_o = 1'b1;
                    // The final ROM word parks the PC on itself so imem_addr
                    // stays inside the ROM while halted.
                    if (pc_i == LAST_PC) begin
                        last_o = 1'b1;
                    end else begin
                        pc_o = pc_i + WORD_BYTES;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid_i) begin
                    pc_o    = align_word(redirect_pc_i);
                    flush_o = 1'b1;
                end
            end
            default: begin
                // BOOT: hold.
            end
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// captures its same-cycle read data into the IF/ID pipeline register.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : if_fetch_stage_if.master (control in, ROM port, IF/ID out, status)
// Parameters:
//   RESET_PC    : PC after reset (ROM word 0)
//   ADDR_WIDTH  : log2 of ROM depth in words
//   COUNT_WIDTH : width of the saturating fetched-instruction counter; must
//                 match the interface instance
// The FSM spends one cycle in BOOT after reset so the ROM output, which is
// zero while reset is held, is never captured. Capturing the last ROM word
// moves to HALT; a redirect leaves HALT.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = TEXT_BASE,
    parameter int          ADDR_WIDTH  = 5,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    if_fetch_stage_if.master   bus
);

    localparam logic [31:0] ROM_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [31:0] LAST_PC   = RESET_PC + WORD_BYTES * (ROM_WORDS - 32'd1);

    fetch_state_e           state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    if_id_t                 if_id_q, if_id_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic advance;
    logic flush;
    logic last;

    if_next_pc #(
        .LAST_PC (LAST_PC)
    ) u_next_pc (
        .state_i          (state_q),
        .pc_i             (pc_q),
        .stall_i          (bus.stall),
        .redirect_valid_i (bus.redirect_valid),
        .redirect_pc_i    (bus.redirect_pc),
        .pc_o             (pc_d),
        .advance_o        (advance),
        .flush_o          (flush),
        .last_o           (last)
    );

    // FSM next state and IF/ID / counter next values.
    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        count_d = count_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    // Flush only invalidates; the stale fields are don't-care.
                    if_id_d.valid = 1'b0;
                end else if (advance) begin
                    if_id_d.valid    = 1'b1;
                    if_id_d.inst     = bus.imem_data;
                    if_id_d.pc       = pc_q;
                    if_id_d.pc_plus4 = pc_q + WORD_BYTES;
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    if (last) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (flush) begin
                    if_id_d.valid = 1'b0;
                    state_d       = ST_RUN;
                end else if (!bus.stall) begin
                    // The halted instruction is handed over once, then bubbles.
                    if_id_d.valid = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            if_id_q <= '{valid: 1'b0, inst: INST_NOP, pc: 32'd0, pc_plus4: 32'd0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    // imem_addr comes straight from the PC flop: no input-to-address path.
    assign bus.imem_addr      = pc_q;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.if_id_inst     = if_id_q.inst;
    assign bus.if_id_pc       = if_id_q.pc;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.halted         = (state_q == ST_HALT);
    assign bus.fetch_count    = count_q;

endmodule
